// File: rtl/fft_r2_engine.sv
// In-place radix-2 DIT FFT/IFFT engine: one butterfly per 6 cycles over a single-port sample SRAM.
// Input is expected in bit-reversed order; the spectrum is left in natural order.
module fft_r2_engine #(
    parameter int LOG2N  = 8,
    parameter int DATA_W = 32,
    parameter int TW_W   = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              inverse,
    input  logic              scale,
    output logic              busy,
    output logic              done,
    output logic [3:0]        stage,
    output logic              mem_cen,
    output logic              mem_wen,
    output logic [LOG2N-1:0]  mem_addr,
    output logic [DATA_W-1:0] mem_dr,
    output logic [DATA_W-1:0] mem_di,
    input  logic [DATA_W-1:0] mem_qr,
    input  logic [DATA_W-1:0] mem_qi,
    output logic              tw_cen,
    output logic [LOG2N-2:0]  tw_addr,
    input  logic [TW_W-1:0]   tw_qr,
    input  logic [TW_W-1:0]   tw_qi
);
    localparam int PW = DATA_W + TW_W + 1;
    localparam logic signed [PW-1:0] RND = PW'(1) <<< (TW_W - 2);

    // FIN is a one-cycle tail after the last write so done lands 3*N*LOG2N+1 cycles after start.
    typedef enum logic [2:0] {IDLE, RDB, RDA, CAPA, MUL, WRA, WRB, FIN} state_t;
    state_t state_q, state_d;

    logic [3:0]       s_q, s_d;
    logic [LOG2N-2:0] j_q, j_d;
    logic [LOG2N-1:0] k_q, k_d;
    logic             done_q;

    logic [LOG2N-1:0] h_w;
    logic [LOG2N-1:0] b_addr;
    logic [LOG2N:0]   k_sum;
    logic [LOG2N-2:0] j_inc;
    logic [LOG2N-2:0] tw_idx;
    logic             j_last;
    logic             s_last;

    assign h_w    = LOG2N'(1) << s_q;
    assign b_addr = k_q + h_w;
    assign k_sum  = {1'b0, k_q} + {h_w, 1'b0};
    assign j_inc  = j_q + (LOG2N-1)'(1);
    assign j_last = ({1'b0, j_q} + LOG2N'(1)) == h_w;
    assign s_last = s_q == 4'(LOG2N - 1);
    assign tw_idx = j_q << (4'(LOG2N - 1) - s_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            j_q     <= j_d;
            k_q     <= k_d;
            done_q  <= (state_q == FIN);
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        j_d     = j_q;
        k_d     = k_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RDB;
                s_d     = '0;
                j_d     = '0;
                k_d     = '0;
            end
            RDB:  state_d = RDA;
            RDA:  state_d = CAPA;
            CAPA: state_d = MUL;
            MUL:  state_d = WRA;
            WRA:  state_d = WRB;
            WRB: begin
                state_d = RDB;
                if (!k_sum[LOG2N]) begin
                    k_d = k_sum[LOG2N-1:0];
                end else if (!j_last) begin
                    j_d = j_inc;
                    k_d = {1'b0, j_inc};
                end else begin
                    j_d = '0;
                    k_d = '0;
                    if (s_last) begin
                        s_d     = '0;
                        state_d = FIN;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic                     inv_q, scl_q;
    logic signed [DATA_W-1:0] b_r_q, b_i_q, u_r_q, u_i_q, t_r_q, t_i_q;
    logic signed [TW_W-1:0]   w_r_q;
    logic signed [TW_W:0]     w_i_q;
    logic signed [TW_W:0]     tw_qi_x;
    logic signed [PW-1:0]     pr_r, pr_i;
    logic signed [DATA_W:0]   sum_r, sum_i, dif_r, dif_i;

    // One extra bit so negating -1.0 for the inverse transform cannot overflow.
    assign tw_qi_x = (TW_W+1)'($signed(tw_qi));
    assign pr_r = PW'(b_r_q) * PW'(w_r_q) - PW'(b_i_q) * PW'(w_i_q);
    assign pr_i = PW'(b_i_q) * PW'(w_r_q) + PW'(b_r_q) * PW'(w_i_q);

    always_ff @(posedge clk) begin
        if (state_q == IDLE && start) begin
            inv_q <= inverse;
            scl_q <= scale;
        end
        if (state_q == RDA) begin
            b_r_q <= mem_qr;
            b_i_q <= mem_qi;
            w_r_q <= tw_qr;
            w_i_q <= inv_q ? -tw_qi_x : tw_qi_x;
        end
        if (state_q == CAPA) begin
            u_r_q <= mem_qr;
            u_i_q <= mem_qi;
        end
        if (state_q == MUL) begin
            t_r_q <= DATA_W'((pr_r + RND) >>> (TW_W - 1));
            t_i_q <= DATA_W'((pr_i + RND) >>> (TW_W - 1));
        end
    end

    assign sum_r = (DATA_W+1)'(u_r_q) + (DATA_W+1)'(t_r_q);
    assign sum_i = (DATA_W+1)'(u_i_q) + (DATA_W+1)'(t_i_q);
    assign dif_r = (DATA_W+1)'(u_r_q) - (DATA_W+1)'(t_r_q);
    assign dif_i = (DATA_W+1)'(u_i_q) - (DATA_W+1)'(t_i_q);

    // Halving takes the upper bits of the widened sum: arithmetic shift, rounding toward -inf.
    function automatic logic [DATA_W-1:0] fold(input logic [DATA_W:0] v, input logic halve);
        return halve ? v[DATA_W:1] : v[DATA_W-1:0];
    endfunction

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign stage    = s_q;
    assign mem_cen  = !(state_q inside {RDB, RDA, WRA, WRB});
    assign mem_wen  = !(state_q inside {WRA, WRB});
    assign mem_addr = (state_q inside {RDB, WRB}) ? b_addr :
                      (state_q inside {RDA, WRA}) ? k_q : '0;
    assign mem_dr   = (state_q == WRB) ? fold(dif_r, scl_q) : fold(sum_r, scl_q);
    assign mem_di   = (state_q == WRB) ? fold(dif_i, scl_q) : fold(sum_i, scl_q);
    assign tw_cen   = (state_q != RDB);
    assign tw_addr  = (state_q == RDB) ? tw_idx : '0;
endmodule
